stage_sequencer: RTL and testbench

Multi-cycle control sequencer for the RockWave core. It steps each instruction through fetch, decode, execute, memory access and writeback by issuing one-cycle stage enables; `decode_en` drives the decode stage's output-register enable. It waits on instruction-memory and data-memory ready handshakes, traps stuck handshakes with a timeout, and counts retired instructions.

---
 rtl/stage_sequencer.sv | 127 ++++++++++++
 tb/tb_stage_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle F/D/E/M/W control sequencer: one-cycle stage enables, ready
// handshakes with a shared wait-state timeout, and a retired-instruction counter.
module stage_sequencer #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 imem_ready,
    input  logic                 mem_access,
    input  logic                 dmem_ready,
    input  logic                 err_clr,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 execute_en,
    output logic                 memaccess_en,
    output logic                 writeback_en,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    // Counter must hold values up to TIMEOUT-1; TIMEOUT of 0 or 1 still gets one bit.
    localparam int WAIT_W = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TIMEOUT_ON = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_ON ? WAIT_W'(TIMEOUT - 1) : '0;

    state_t                state_reg;
    state_t                state_next;
    logic [WAIT_W-1:0]     wait_reg;
    logic [WAIT_W-1:0]     wait_next;
    logic [CNT_WIDTH-1:0]  retired_reg;
    logic                  wait_expired;

    assign wait_expired = TIMEOUT_ON && (wait_reg == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            wait_reg    <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == S_WRITEBACK) begin
                retired_reg <= retired_reg + CNT_WIDTH'(1);
            end
        end
    end

    // The wait counter only survives a not-ready cycle in FETCH/MEMORY, so
    // every other path leaves it at zero for the next wait-state entry.
    always_comb begin
        state_next   = state_reg;
        wait_next    = '0;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        memaccess_en = 1'b0;
        writeback_en = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    fetch_en   = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                decode_en  = 1'b1;
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                execute_en = 1'b1;
                state_next = mem_access ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    memaccess_en = 1'b1;
                    state_next   = S_WRITEBACK;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                writeback_en = 1'b1;
                state_next   = run ? S_FETCH : S_IDLE;
            end
            S_ERROR: begin
                if (err_clr) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_reg != S_IDLE) && (state_reg != S_ERROR);
    assign timeout_err = (state_reg == S_ERROR);
    assign retired     = retired_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Cycle-by-cycle vector bench for stage_sequencer (CNT_WIDTH=3, TIMEOUT=4),
// plus a hand-written asynchronous reset sequence.
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run, imem_ready, mem_access, dmem_ready, err_clr;
    logic       fetch_en, decode_en, execute_en, memaccess_en, writeback_en;
    logic       busy, timeout_err;
    logic [2:0] retired;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    stage_sequencer #(.CNT_WIDTH(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .err_clr(err_clr),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memaccess_en(memaccess_en), .writeback_en(writeback_en),
        .busy(busy), .timeout_err(timeout_err), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    // Inputs {run, imem_ready, mem_access, dmem_ready, err_clr}; enables
    // {fetch, decode, execute, memaccess, writeback}; all values hold for one cycle.
    typedef struct {
        logic [4:0] in_bits;
        logic [2:0] st;
        logic [4:0] en;
        logic       busy;
        logic       terr;
        logic [2:0] ret;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic void add(input logic [4:0] in_bits, input int st,
                                input logic [4:0] en, input int ret);
        vec_t v;
        v.in_bits = in_bits;
        v.st      = 3'(st);
        v.en      = en;
        v.busy    = (st != 0) && (st != 6);
        v.terr    = (st == 6);
        v.ret     = 3'(ret);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"}, 32'(state), 32'd0);
        check({tag, " enables"}, 32'({fetch_en, decode_en, execute_en, memaccess_en, writeback_en}), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, " retired"}, 32'(retired), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cur;
        vec_t exp;
        logic [4:0] en_act;

        // Three back-to-back non-memory instructions, run dropped in the last WB.
        add(5'b11000, 0, 5'b00000, 0);
        for (int k = 0; k < 3; k++) begin
            add(5'b11000, 1, 5'b10000, k);
            add(5'b11000, 2, 5'b01000, k);
            add(5'b11000, 3, 5'b00100, k);
            add((k == 2) ? 5'b01000 : 5'b11000, 5, 5'b00001, k);
        end
        add(5'b00000, 0, 5'b00000, 3);
        // Memory instruction: imem 2 waits, dmem 3 waits (last permitted cycle).
        add(5'b10000, 0, 5'b00000, 3);
        add(5'b10000, 1, 5'b00000, 3);
        add(5'b10000, 1, 5'b00000, 3);
        add(5'b11000, 1, 5'b10000, 3);
        add(5'b10000, 2, 5'b01000, 3);
        add(5'b10100, 3, 5'b00100, 3);
        add(5'b10000, 4, 5'b00000, 3);
        add(5'b10000, 4, 5'b00000, 3);
        add(5'b10000, 4, 5'b00000, 3);
        add(5'b10010, 4, 5'b00010, 3);
        add(5'b00000, 5, 5'b00001, 3);
        add(5'b00000, 0, 5'b00000, 4);
        // Fetch timeout after 4 not-ready cycles, then err_clr.
        add(5'b10000, 0, 5'b00000, 4);
        for (int k = 0; k < 4; k++) add(5'b10000, 1, 5'b00000, 4);
        add(5'b10000, 6, 5'b00000, 4);
        add(5'b00001, 6, 5'b00000, 4);
        add(5'b00000, 0, 5'b00000, 4);
        // Ready in the 4th cycle, run dropped in DECODE, err_clr in IDLE ignored.
        add(5'b10000, 0, 5'b00000, 4);
        for (int k = 0; k < 3; k++) add(5'b10000, 1, 5'b00000, 4);
        add(5'b11000, 1, 5'b10000, 4);
        add(5'b00000, 2, 5'b01000, 4);
        add(5'b00000, 3, 5'b00100, 4);
        add(5'b00000, 5, 5'b00001, 4);
        add(5'b00001, 0, 5'b00000, 5);
        add(5'b00000, 0, 5'b00000, 5);
        // Memory-stage timeout; retired must survive ERROR.
        add(5'b10000, 0, 5'b00000, 5);
        add(5'b11000, 1, 5'b10000, 5);
        add(5'b10000, 2, 5'b01000, 5);
        add(5'b10100, 3, 5'b00100, 5);
        for (int k = 0; k < 4; k++) add(5'b10000, 4, 5'b00000, 5);
        add(5'b10000, 6, 5'b00000, 5);
        add(5'b00001, 6, 5'b00000, 5);
        add(5'b00000, 0, 5'b00000, 5);
        // Four more instructions wrap retired 7->0, ending at 1; stray
        // mem_access/err_clr outside EXECUTE/ERROR must be ignored.
        add(5'b10000, 0, 5'b00000, 5);
        for (int k = 0; k < 4; k++) begin
            add(5'b11101, 1, 5'b10000, (5 + k) % 8);
            add(5'b10101, 2, 5'b01000, (5 + k) % 8);
            add(5'b10000, 3, 5'b00100, (5 + k) % 8);
            add((k == 3) ? 5'b00101 : 5'b10101, 5, 5'b00001, (5 + k) % 8);
        end
        add(5'b00000, 0, 5'b00000, 1);

        rst = 1'b1;
        {run, imem_ready, mem_access, dmem_ready, err_clr} = 5'b00000;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            @(negedge clk);
            {run, imem_ready, mem_access, dmem_ready, err_clr} = cur.in_bits;
            sb.push_back(cur);
            #2;
            exp = sb.pop_front();
            en_act = {fetch_en, decode_en, execute_en, memaccess_en, writeback_en};
            checks++;
            if (state !== exp.st || en_act !== exp.en || busy !== exp.busy ||
                timeout_err !== exp.terr || retired !== exp.ret) begin
                failures++;
                $display("FAIL vec%0d: got st=%0d en=%b busy=%b terr=%b ret=%0d expected st=%0d en=%b busy=%b terr=%b ret=%0d",
                         i, state, en_act, busy, timeout_err, retired,
                         exp.st, exp.en, exp.busy, exp.terr, exp.ret);
            end
            $display("vec%0d in=%b st=%0d en=%b ret=%0d", i, cur.in_bits, state, en_act, retired);
        end

        // Asynchronous reset in the middle of MEMORY.
        @(negedge clk); {run, imem_ready, mem_access, dmem_ready, err_clr} = 5'b10000;
        @(negedge clk); {run, imem_ready, mem_access, dmem_ready, err_clr} = 5'b11000;
        @(negedge clk); {run, imem_ready, mem_access, dmem_ready, err_clr} = 5'b10000;
        @(negedge clk); {run, imem_ready, mem_access, dmem_ready, err_clr} = 5'b10100;
        @(negedge clk); {run, imem_ready, mem_access, dmem_ready, err_clr} = 5'b10000;
        #2;
        check("pre-reset state", 32'(state), 32'd4);
        dmem_ready = 1'b1;
        #1;
        check("pre-reset memaccess_en", 32'(memaccess_en), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async reset");
        $display("async reset mid-MEMORY st=%0d ret=%0d", state, retired);
        @(negedge clk);
        check_reset_outputs("reset held");
        rst = 1'b0;
        {run, imem_ready, mem_access, dmem_ready, err_clr} = 5'b11000;
        #2;
        check("post-reset idle", 32'(state), 32'd0);
        @(negedge clk);
        #2;
        check("post-reset fetch", 32'(state), 32'd1);
        check("post-reset fetch_en", 32'(fetch_en), 32'd1);
        $display("restart st=%0d fetch_en=%b", state, fetch_en);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
